// File: rtl/datapath_mem_hs_pkg.sv
// Shared encodings for the multicycle datapath and its handshaked memory port.
package datapath_mem_hs_pkg;

  typedef enum logic [1:0] {
    MEM_FETCH   = 2'b00,
    MEM_LOAD    = 2'b01,
    MEM_STORE   = 2'b10,
    MEM_ILLEGAL = 2'b11
  } mem_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } mem_state_e;

  localparam logic [1:0] PC_SRC_ALU   = 2'd0;
  localparam logic [1:0] PC_SRC_REG_B = 2'd1;
  localparam logic [1:0] PC_SRC_INC   = 2'd2;
  localparam logic [1:0] PC_SRC_HOLD  = 2'd3;

  localparam logic [1:0] RW_SRC_ALU = 2'd0;
  localparam logic [1:0] RW_SRC_MDR = 2'd1;
  localparam logic [1:0] RW_SRC_INC = 2'd2;
  localparam logic [1:0] RW_SRC_IMM = 2'd3;

  localparam logic [5:0] ALU_ADD    = 6'd0;
  localparam logic [5:0] ALU_SUB    = 6'd1;
  localparam logic [5:0] ALU_AND    = 6'd2;
  localparam logic [5:0] ALU_OR     = 6'd3;
  localparam logic [5:0] ALU_XOR    = 6'd4;
  localparam logic [5:0] ALU_SLL    = 6'd5;
  localparam logic [5:0] ALU_SRL    = 6'd6;
  localparam logic [5:0] ALU_PASS_B = 6'd7;

  // Timeout counter width; a disabled timeout still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/datapath_mem_hs_mem_port_fsm.sv
// Memory-port sequencer: request/ack handshake, timeout, holding registers
// and the IR/MDR load strobes for the datapath.
module datapath_mem_hs_mem_port_fsm
  import datapath_mem_hs_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_start,
  input  logic [1:0]       mem_kind,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] reg_a,
  input  logic [WIDTH-1:0] reg_b,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             mem_err,
  output logic             ir_load_c,
  output logic             mdr_load_c
);

  localparam int unsigned CNT_W = cnt_width(MEM_TIMEOUT);

  mem_state_e       state_q, state_d;
  mem_kind_e        kind_q, kind_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             timeout_hit;

  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      kind_q  <= MEM_FETCH;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_start && (mem_kind != MEM_ILLEGAL)) state_d = ST_REQ;
      ST_REQ: begin
        if (mem_ack)          state_d = ST_DONE;
        else if (timeout_hit) state_d = ST_ERR;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_ERR;
    endcase
  end

  // Holding registers, counter and registered outputs
  always_comb begin
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
      kind_d  = mem_kind_e'(mem_kind);
      cnt_d   = '0;
      addr_d  = (mem_kind == MEM_FETCH) ? pc : reg_b;
      we_d    = (mem_kind == MEM_STORE);
      wdata_d = (mem_kind == MEM_STORE) ? reg_a : '0;
    end else if (state_q == ST_REQ) begin
      if (state_d == ST_REQ) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        we_d    = 1'b0;
        wdata_d = '0;
      end
    end
    req_d  = (state_d == ST_REQ);
    busy_d = (state_d == ST_REQ);
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERR);
  end

  assign ir_load_c  = (state_q == ST_REQ) && mem_ack && (kind_q == MEM_FETCH);
  assign mdr_load_c = (state_q == ST_REQ) && mem_ack && (kind_q == MEM_LOAD);

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_err   = err_q;

endmodule

// File: rtl/datapath_mem_hs.sv
// Multicycle CPU datapath (PC, regfile, A/B latches, ALU, IR, MDR) with a
// handshaked memory port; architectural writes stall while an access is in flight.
module datapath_mem_hs
  import datapath_mem_hs_pkg::*;
#(
  parameter int unsigned WIDTH            = 16,
  parameter int unsigned REG_BITS         = 4,
  parameter int unsigned ALU_CONT_BITS    = 6,
  parameter int unsigned OP_CODE_BITS     = 4,
  parameter int unsigned EXT_OP_CODE_BITS = 4,
  parameter int unsigned MEM_TIMEOUT      = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        reg_write,
  input  logic                        alu_A_src,
  input  logic                        alu_B_src,
  input  logic                        pc_en,
  input  logic [1:0]                  pc_src,
  input  logic [1:0]                  reg_write_src,
  input  logic [ALU_CONT_BITS-1:0]    alu_cont,
  input  logic                        mem_start,
  input  logic [1:0]                  mem_kind,
  input  logic                        mem_ack,
  input  logic [WIDTH-1:0]            mem_rdata,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [WIDTH-1:0]            mem_addr,
  output logic [WIDTH-1:0]            mem_wdata,
  output logic                        busy,
  output logic                        done,
  output logic                        mem_err,
  output logic [OP_CODE_BITS-1:0]     op_code,
  output logic [EXT_OP_CODE_BITS-1:0] ext_op_code,
  output logic [REG_BITS-1:0]         A_index,
  output logic [REG_BITS-1:0]         B_index,
  output logic [WIDTH-1:0]            psr_flags
);

  localparam int unsigned NUM_REGS = 1 << REG_BITS;
  localparam int unsigned SH_W     = $clog2(WIDTH);
  localparam int unsigned MSB      = WIDTH - 1;

  logic [WIDTH-1:0]    pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, psr_q, psr_d;
  logic [WIDTH-1:0]    rf_q [NUM_REGS];
  logic [WIDTH-1:0]    rf_d [NUM_REGS];
  logic [REG_BITS-1:0] a_idx, b_idx;
  logic [WIDTH-1:0]    imm, pc_inc, alu_a, alu_b, alu_out, rw_data;
  logic [WIDTH:0]      alu_wide;
  logic                carry, ovf, busy_w, pc_en_g, reg_write_g;
  logic                ir_load_c, mdr_load_c;

  datapath_mem_hs_mem_port_fsm #(
    .WIDTH       (WIDTH),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_port_fsm (
    .clk        (clk),
    .reset      (reset),
    .mem_start  (mem_start),
    .mem_kind   (mem_kind),
    .mem_ack    (mem_ack),
    .pc         (pc_q),
    .reg_a      (a_q),
    .reg_b      (b_q),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy_w),
    .done       (done),
    .mem_err    (mem_err),
    .ir_load_c  (ir_load_c),
    .mdr_load_c (mdr_load_c)
  );

  assign busy  = busy_w;
  assign a_idx = REG_BITS'(ir_q[11:8]);
  assign b_idx = REG_BITS'(ir_q[3:0]);
  assign imm   = WIDTH'(ir_q[7:0]);

  // ALU and flags; flags are {negative, overflow, zero, carry/borrow} in the low bits
  always_comb begin
    alu_a    = alu_A_src ? a_q : pc_q;
    alu_b    = alu_B_src ? imm : b_q;
    alu_wide = '0;
    alu_out  = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    case (alu_cont)
      ALU_ADD: begin
        alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out  = alu_wide[WIDTH-1:0];
        carry    = alu_wide[WIDTH];
        ovf      = (alu_a[MSB] == alu_b[MSB]) && (alu_out[MSB] != alu_a[MSB]);
      end
      ALU_SUB: begin
        alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
        alu_out  = alu_wide[WIDTH-1:0];
        carry    = alu_wide[WIDTH];
        ovf      = (alu_a[MSB] != alu_b[MSB]) && (alu_out[MSB] != alu_a[MSB]);
      end
      ALU_AND:    alu_out = alu_a & alu_b;
      ALU_OR:     alu_out = alu_a | alu_b;
      ALU_XOR:    alu_out = alu_a ^ alu_b;
      ALU_SLL:    alu_out = alu_a << alu_b[SH_W-1:0];
      ALU_SRL:    alu_out = alu_a >> alu_b[SH_W-1:0];
      ALU_PASS_B: alu_out = alu_b;
      default:    alu_out = alu_a;
    endcase
    psr_d = WIDTH'({alu_out[MSB], ovf, (alu_out == '0), carry});
  end

  // Architectural next-state; PC and regfile writes are gated off during an access
  always_comb begin
    pc_en_g     = pc_en & ~busy_w;
    reg_write_g = reg_write & ~busy_w;
    pc_inc      = pc_q + WIDTH'(1);
    pc_d        = pc_q;
    if (pc_en_g) begin
      case (pc_src)
        PC_SRC_ALU:   pc_d = alu_out;
        PC_SRC_REG_B: pc_d = b_q;
        PC_SRC_INC:   pc_d = pc_inc;
        default:      pc_d = pc_q;
      endcase
    end
    case (reg_write_src)
      RW_SRC_ALU: rw_data = alu_out;
      RW_SRC_MDR: rw_data = mdr_q;
      RW_SRC_INC: rw_data = pc_inc;
      default:    rw_data = imm;
    endcase
    rf_d = rf_q;
    if (reg_write_g) rf_d[a_idx] = rw_data;
    a_d   = rf_q[a_idx];
    b_d   = rf_q[b_idx];
    ir_d  = ir_load_c ? mem_rdata : ir_q;
    mdr_d = mdr_load_c ? mem_rdata : mdr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mdr_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      psr_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mdr_q <= mdr_d;
      a_q   <= a_d;
      b_q   <= b_d;
      psr_q <= psr_d;
      rf_q  <= rf_d;
    end
  end

  assign op_code     = OP_CODE_BITS'(ir_q[15:12]);
  assign ext_op_code = EXT_OP_CODE_BITS'(ir_q[7:4]);
  assign A_index     = a_idx;
  assign B_index     = b_idx;
  assign psr_flags   = psr_q;

endmodule

// File: tb/tb_datapath_mem_hs.sv
// Randomized self-checking bench for datapath_mem_hs against an architectural model.
module tb_datapath_mem_hs;

  localparam logic [1:0] K_FETCH = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;
  localparam logic [1:0] K_ILL   = 2'd3;

  logic        clk = 1'b0;
  logic        reset, reg_write, alu_A_src, alu_B_src, pc_en;
  logic [1:0]  pc_src, reg_write_src, mem_kind;
  logic [5:0]  alu_cont;
  logic        mem_start, mem_ack;
  logic [15:0] mem_rdata;
  logic        mem_req, mem_we, busy, done, mem_err;
  logic [15:0] mem_addr, mem_wdata, psr_flags;
  logic [3:0]  op_code, ext_op_code, A_index, B_index;

  always #5 clk = ~clk;

  datapath_mem_hs #(
    .WIDTH(16), .REG_BITS(4), .ALU_CONT_BITS(6),
    .OP_CODE_BITS(4), .EXT_OP_CODE_BITS(4), .MEM_TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset), .reg_write(reg_write), .alu_A_src(alu_A_src),
    .alu_B_src(alu_B_src), .pc_en(pc_en), .pc_src(pc_src),
    .reg_write_src(reg_write_src), .alu_cont(alu_cont), .mem_start(mem_start),
    .mem_kind(mem_kind), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .mem_err(mem_err),
    .op_code(op_code), .ext_op_code(ext_op_code), .A_index(A_index),
    .B_index(B_index), .psr_flags(psr_flags)
  );

  int checks = 0;
  int errors = 0;

  // Architectural model state
  logic [15:0] m_pc, m_ir, m_mdr;
  logic [15:0] m_rf [16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Returns {n, v, z, c, result}
  function automatic logic [19:0] ref_alu(input int op, input logic [15:0] a, input logic [15:0] b);
    int unsigned ua, ub, full;
    int          sa, sb, sr;
    logic [15:0] r;
    logic        c, v;
    ua = a; ub = b;
    sa = int'($signed(a)); sb = int'($signed(b));
    c = 1'b0; v = 1'b0;
    case (op)
      0: begin full = ua + ub; r = 16'(full); c = (full > 32'hFFFF);
               sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
      1: begin r = 16'(ua - ub); c = (ua < ub);
               sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 16'(ua << (ub % 16));
      6: r = 16'(ua >> (ub % 16));
      7: r = b;
      default: r = a;
    endcase
    return {r[15], v, (r == 16'h0), c, r};
  endfunction

  function automatic int rand_op();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 63)) : int'($urandom_range(0, 7));
  endfunction

  task automatic model_reset();
    m_pc = '0; m_ir = '0; m_mdr = '0;
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
  endtask

  task automatic access(input logic [1:0] kind, input int waits, input logic [15:0] rdata, input bit stall);
    logic [15:0] ea, ewd;
    logic        ewe;
    ea  = (kind == K_FETCH) ? m_pc : m_rf[m_ir[3:0]];
    ewe = (kind == K_STORE);
    ewd = ewe ? m_rf[m_ir[11:8]] : 16'h0;
    mem_kind  = kind;
    mem_start = 1'b1;
    @(negedge clk);
    mem_start = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      check_eq("req_status", 32'({mem_req, busy, done, mem_we, mem_err}), 32'({1'b1, 1'b1, 1'b0, ewe, 1'b0}));
      check_eq("req_addr", 32'(mem_addr), 32'(ea));
      check_eq("req_wdata", 32'(mem_wdata), 32'(ewd));
      mem_ack       = (i == waits);
      mem_rdata     = (i == waits) ? rdata : 16'($urandom);
      pc_en         = stall && (i != waits);
      reg_write     = stall && (i != waits);
      pc_src        = 2'd2;
      reg_write_src = 2'd3;
      mem_start     = (i != waits) ? 1'($urandom) : 1'b0;
      @(negedge clk);
    end
    mem_ack = 1'b0; pc_en = 1'b0; reg_write = 1'b0; mem_start = 1'b0;
    if (kind == K_FETCH) m_ir = rdata;
    if (kind == K_LOAD)  m_mdr = rdata;
    check_eq("done_status", 32'({mem_req, busy, done, mem_we, mem_err}), 32'(5'b00100));
    check_eq("done_wdata", 32'(mem_wdata), 32'h0);
    check_eq("ir_fields", 32'({op_code, A_index, ext_op_code, B_index}), 32'(m_ir));
    @(negedge clk);
    check_eq("post_done", 32'({mem_req, busy, done}), 32'h0);
  endtask

  task automatic do_pc(input logic [1:0] src, input bit asel, input bit bsel, input int op);
    logic [15:0] av, bv, nxt;
    logic [19:0] ar;
    av = asel ? m_rf[m_ir[11:8]] : m_pc;
    bv = bsel ? {8'h00, m_ir[7:0]} : m_rf[m_ir[3:0]];
    ar = ref_alu(op, av, bv);
    case (src)
      2'd0:    nxt = ar[15:0];
      2'd1:    nxt = m_rf[m_ir[3:0]];
      2'd2:    nxt = 16'(m_pc + 16'd1);
      default: nxt = m_pc;
    endcase
    pc_en = 1'b1; pc_src = src; alu_A_src = asel; alu_B_src = bsel; alu_cont = 6'(op);
    @(negedge clk);
    pc_en = 1'b0;
    check_eq("psr_flags", 32'(psr_flags), 32'({12'h000, ar[19:16]}));
    m_pc = nxt;
    @(negedge clk);
  endtask

  task automatic do_rw(input logic [1:0] src, input bit asel, input bit bsel, input int op);
    logic [15:0] av, bv, wd;
    logic [19:0] ar;
    av = asel ? m_rf[m_ir[11:8]] : m_pc;
    bv = bsel ? {8'h00, m_ir[7:0]} : m_rf[m_ir[3:0]];
    ar = ref_alu(op, av, bv);
    case (src)
      2'd0:    wd = ar[15:0];
      2'd1:    wd = m_mdr;
      2'd2:    wd = 16'(m_pc + 16'd1);
      default: wd = {8'h00, m_ir[7:0]};
    endcase
    reg_write = 1'b1; reg_write_src = src; alu_A_src = asel; alu_B_src = bsel; alu_cont = 6'(op);
    @(negedge clk);
    reg_write = 1'b0;
    check_eq("psr_flags_rw", 32'(psr_flags), 32'({12'h000, ar[19:16]}));
    m_rf[m_ir[11:8]] = wd;
    @(negedge clk);
  endtask

  // Architectural register write: fetch an instruction naming r, load val, commit MDR.
  task automatic write_reg(input logic [3:0] r, input logic [15:0] val);
    access(K_FETCH, 0, {4'h0, r, 4'h0, r}, 1'b0);
    access(K_LOAD, int'($urandom_range(0, 2)), val, 1'b0);
    do_rw(2'd1, 1'b0, 1'b0, 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; reg_write = 1'b0; alu_A_src = 1'b0; alu_B_src = 1'b0; pc_en = 1'b0;
    pc_src = 2'd0; reg_write_src = 2'd0; alu_cont = 6'd0; mem_start = 1'b0;
    mem_kind = K_FETCH; mem_ack = 1'b0; mem_rdata = 16'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();

    check_eq("reset_status", 32'({mem_req, busy, done, mem_we, mem_err}), 32'h0);
    check_eq("reset_addr", 32'(mem_addr), 32'h0);
    check_eq("reset_ir", 32'({op_code, A_index, ext_op_code, B_index}), 32'h0);
    check_eq("reset_psr", 32'(psr_flags), 32'h0);

    // Fetch 0-wait at PC=4
    access(K_FETCH, 0, 16'h0004, 1'b0);
    do_pc(2'd0, 1'b0, 1'b1, 0);
    access(K_FETCH, 0, 16'h1234, 1'b0);
    check_eq("fetch_fields", 32'({op_code, A_index, B_index}), 32'h124);

    // Load with 3 wait states, then commit MDR to the register file
    write_reg(4'd4, 16'h0100);
    access(K_FETCH, 0, 16'h1234, 1'b0);
    access(K_LOAD, 3, 16'hBEEF, 1'b0);
    do_rw(2'd1, 1'b0, 1'b0, 0);
    access(K_STORE, 0, 16'h0000, 1'b0);
    check_eq("load_commit_wdata", 32'(mem_wdata), 32'h0);

    // Store with held address/data; IR and MDR untouched
    write_reg(4'd2, 16'h5A5A);
    write_reg(4'd4, 16'h0200);
    access(K_FETCH, 0, 16'h1234, 1'b0);
    access(K_STORE, 2, 16'hDEAD, 1'b0);
    do_rw(2'd1, 1'b0, 1'b0, 0);
    access(K_STORE, 1, 16'h0000, 1'b0);

    // Stall gating, then PC write after the access completes
    access(K_LOAD, 3, 16'h7777, 1'b1);
    access(K_STORE, 0, 16'h0000, 1'b0);
    access(K_FETCH, 0, 16'h1234, 1'b0);
    do_pc(2'd2, 1'b0, 1'b0, 0);
    access(K_FETCH, 1, 16'h1234, 1'b0);

    // PC+1 wrap at 0xFFFF
    write_reg(4'd5, 16'hFFFF);
    do_pc(2'd1, 1'b0, 1'b0, 0);
    access(K_FETCH, 0, 16'h0505, 1'b0);
    do_pc(2'd2, 1'b0, 1'b0, 0);
    access(K_FETCH, 0, 16'h0505, 1'b0);
    check_eq("pc_wrapped", 32'(m_pc), 32'h0);

    // Randomized mix of accesses and architectural updates
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 5))
        0, 1: access(2'($urandom_range(0, 2)), int'($urandom_range(0, 4)), 16'($urandom), 1'($urandom));
        2:    do_pc(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), rand_op());
        3:    do_rw(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), rand_op());
        4:    write_reg(4'($urandom), 16'($urandom));
        default: access(K_FETCH, int'($urandom_range(0, 2)), 16'($urandom), 1'b0);
      endcase
    end

    // Timeout: exactly 15 request cycles, then sticky error
    mem_kind = K_FETCH; mem_start = 1'b1;
    @(negedge clk);
    mem_start = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) n++;
      @(negedge clk);
    end
    check_eq("timeout_req_cycles", 32'(n), 32'd15);
    check_eq("timeout_status", 32'({mem_req, busy, done, mem_err}), 32'(4'b0001));
    mem_start = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    mem_start = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    check_eq("err_ignores_start", 32'({mem_req, busy, done, mem_err}), 32'(4'b0001));
    apply_reset();
    check_eq("err_cleared", 32'({mem_req, busy, done, mem_err}), 32'h0);

    // Reset in the second request cycle
    write_reg(4'd3, 16'h00AA);
    do_pc(2'd0, 1'b0, 1'b1, 0);
    mem_kind = K_FETCH; mem_start = 1'b1;
    @(negedge clk);
    mem_start = 1'b0;
    @(negedge clk);
    check_eq("req_cycle2", 32'(mem_req), 32'h1);
    apply_reset();
    check_eq("rst_mid_status", 32'({mem_req, busy, done, mem_we, mem_err}), 32'h0);
    check_eq("rst_mid_psr", 32'(psr_flags), 32'h0);
    check_eq("rst_mid_ir", 32'({op_code, A_index, ext_op_code, B_index}), 32'h0);
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq("stray_ack", 32'({mem_req, busy, done}), 32'h0);
    @(negedge clk);
    check_eq("stray_ack_ir", 32'({op_code, A_index, ext_op_code, B_index}), 32'h0);
    mem_kind = K_ILL; mem_start = 1'b1;
    @(negedge clk);
    mem_start = 1'b0;
    check_eq("illegal_kind", 32'({mem_req, busy, done}), 32'h0);
    @(negedge clk);
    check_eq("illegal_kind_2", 32'({mem_req, busy, done, mem_err}), 32'h0);
    access(K_FETCH, 1, 16'h4321, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
